// File: rtl/ram_out_pkg.sv
// Shared state encoding and sizing helpers for the result-RAM output streamer.
// The helpers let the top and any surrounding blocks derive the same widths from DIM.
package ram_out_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_ADVANCE = 3'd4,
        S_RECOVER = 3'd5
    } state_t;

    localparam int DEFAULT_DIM = 3;

    function automatic int frame_len(input int dim);
        return dim * dim;
    endfunction

    // Width of the address counter: it must hold DIM*DIM-1.
    function automatic int cnt_width(input int dim);
        return $clog2(dim * dim - 1) + 1;
    endfunction

    localparam int FRAME_LEN = frame_len(DEFAULT_DIM);

endpackage

// File: rtl/ram_out_streamer.sv
// Drains one DIM x DIM result frame from the output RAM onto a valid/ready stream,
// stepping the external address counter and realigning it to 0 after an abort.
module ram_out_streamer
    import ram_out_pkg::*;
#(
    parameter int DIM    = 3,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = cnt_width(DIM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cnt_in,
    output logic              ram_rd_en,
    output logic [CNT_W-1:0]  ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              signal_up,
    output logic              signal_up_recover,
    output logic              busy,
    output logic              done
);

    localparam int                LAT_W     = 3;
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0]  LAST_ADDR = CNT_W'(frame_len(DIM) - 1);

    state_t           state;
    logic [LAT_W-1:0] lat_cnt;

    assign ram_addr = cnt_in;

    // Decoded from live cnt_in so the pulse stops in the very cycle the counter reads 0.
    assign signal_up_recover = (state == S_RECOVER) && (cnt_in != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            lat_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            ram_rd_en <= 1'b0;
            signal_up <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state inside {S_READ, S_WAIT, S_PRESENT, S_ADVANCE})) begin
                state     <= S_RECOVER;
                out_valid <= 1'b0;
                ram_rd_en <= 1'b0;
                signal_up <= 1'b0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            busy <= 1'b1;
                            if (cnt_in == '0) begin
                                state     <= S_READ;
                                ram_rd_en <= 1'b1;
                            end else begin
                                state <= S_RECOVER;
                            end
                        end
                    end
                    S_READ: begin
                        ram_rd_en <= 1'b0;
                        lat_cnt   <= LAT_INIT;
                        state     <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (lat_cnt == '0) begin
                            out_data  <= ram_rdata;
                            out_valid <= 1'b1;
                            state     <= S_PRESENT;
                        end else begin
                            lat_cnt <= lat_cnt - LAT_W'(1);
                        end
                    end
                    S_PRESENT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            signal_up <= 1'b1;
                            state     <= S_ADVANCE;
                        end
                    end
                    S_ADVANCE: begin
                        signal_up <= 1'b0;
                        // The counter wraps by itself on the last word, so no recovery is needed.
                        if (cnt_in == LAST_ADDR) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            ram_rd_en <= 1'b1;
                            state     <= S_READ;
                        end
                    end
                    S_RECOVER: begin
                        if (cnt_in == '0) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        ram_rd_en <= 1'b0;
                        signal_up <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram_out_streamer.sv
// Scoreboard bench for ram_out_streamer: two instances (RD_LAT=1 and RD_LAT=3), each with
// its own address counter and RAM model holding data = addr*3.
module tb_ram_out_streamer;

    localparam int DIM    = 3;
    localparam int DATA_W = 16;
    localparam int FRAME  = DIM * DIM;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              a_start, a_abort, a_ready, a_rd_en, a_valid, a_up, a_rec, a_busy, a_done;
    logic              extra_up;
    logic [CNT_W-1:0]  a_cnt, a_addr;
    logic [DATA_W-1:0] a_rdata, a_data;

    logic              b_start, b_abort, b_ready, b_rd_en, b_valid, b_up, b_rec, b_busy, b_done;
    logic [CNT_W-1:0]  b_cnt, b_addr;
    logic [DATA_W-1:0] b_rdata, b_data, b_p1, b_p2;

    ram_out_streamer #(.DIM(DIM), .DATA_W(DATA_W), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .cnt_in(a_cnt),
        .ram_rd_en(a_rd_en), .ram_addr(a_addr), .ram_rdata(a_rdata),
        .out_data(a_data), .out_valid(a_valid), .out_ready(a_ready),
        .signal_up(a_up), .signal_up_recover(a_rec), .busy(a_busy), .done(a_done)
    );

    ram_out_streamer #(.DIM(DIM), .DATA_W(DATA_W), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .cnt_in(b_cnt),
        .ram_rd_en(b_rd_en), .ram_addr(b_addr), .ram_rdata(b_rdata),
        .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready),
        .signal_up(b_up), .signal_up_recover(b_rec), .busy(b_busy), .done(b_done)
    );

    // Address counters: wrap at FRAME-1, no synchronous clear, reset by the shared rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) a_cnt <= '0;
        else if (a_up || a_rec || extra_up) a_cnt <= (a_cnt == CNT_W'(FRAME - 1)) ? '0 : a_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) b_cnt <= '0;
        else if (b_up || b_rec) b_cnt <= (b_cnt == CNT_W'(FRAME - 1)) ? '0 : b_cnt + 4'd1;
    end

    // RAM models return garbage unless sampled exactly RD_LAT cycles after the strobe.
    always_ff @(posedge clk) a_rdata <= a_rd_en ? 16'(a_addr) * 16'd3 : 16'hBEEF;

    always_ff @(posedge clk) begin
        b_p1    <= b_rd_en ? 16'(b_addr) * 16'd3 : 16'hDEAD;
        b_p2    <= b_p1;
        b_rdata <= b_p2;
    end

    int errors = 0;
    int checks = 0;
    int exp_a[$];
    int exp_b[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drives a one-cycle pulse, launched and cleared on falling edges.
    task automatic applyStimulus(input int code);
        @(negedge clk);
        case (code)
            0: a_start  = 1'b1;
            1: b_start  = 1'b1;
            default: extra_up = 1'b1;
        endcase
        @(negedge clk);
        a_start  = 1'b0;
        b_start  = 1'b0;
        extra_up = 1'b0;
    endtask

    task automatic pushFrame(input bit to_b);
        for (int i = 0; i < FRAME; i++) begin
            if (to_b) exp_b.push_back(i * 3);
            else      exp_a.push_back(i * 3);
        end
    endtask

    // Monitor A: scoreboard pops on every accepted beat.
    bit a_pv = 0, a_prd = 0, a_pacc = 0, a_pdone = 0;
    logic [DATA_W-1:0] a_pdata = '0;
    int a_last = -1, a_gap = 0, a_rdcyc = 0;
    int a_beats = 0, a_ups = 0, a_recs = 0, a_dones = 0;

    always begin
        @(negedge clk);
        #1;
        if (a_rd_en) begin
            checkOutput("a_rd_en_single", 32'(a_prd), 0);
            a_rdcyc = cyc;
        end
        if (a_valid && !a_pv) checkOutput("a_read_latency", cyc - a_rdcyc, 2);
        if (a_valid && a_pv && !a_pacc) checkOutput("a_hold_data", 32'(a_data), 32'(a_pdata));
        if (a_valid && a_ready) begin
            a_beats++;
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL a_unexpected_beat: got data %0d expected no beat", a_data);
            end else begin
                checkOutput("a_beat_data", 32'(a_data), exp_a.pop_front());
            end
            if (a_gap != 0 && a_last >= 0) checkOutput("a_beat_spacing", cyc - a_last, a_gap);
            a_last = cyc;
        end
        if (a_up || a_rec) checkOutput("a_up_rec_exclusive", 32'(a_up & a_rec), 0);
        if (a_done) checkOutput("a_done_single", 32'(a_pdone), 0);
        a_ups   += int'(a_up);
        a_recs  += int'(a_rec);
        a_dones += int'(a_done);
        a_pv    = a_valid;
        a_prd   = a_rd_en;
        a_pacc  = a_valid && a_ready;
        a_pdone = a_done;
        a_pdata = a_data;
    end

    // Monitor B: same checks with the RD_LAT=3 timing.
    bit b_pv = 0, b_prd = 0, b_pacc = 0;
    logic [DATA_W-1:0] b_pdata = '0;
    int b_last = -1, b_rdcyc = 0, b_beats = 0, b_ups = 0;

    always begin
        @(negedge clk);
        #1;
        if (b_rd_en) begin
            checkOutput("b_rd_en_single", 32'(b_prd), 0);
            b_rdcyc = cyc;
        end
        if (b_valid && !b_pv) checkOutput("b_read_latency", cyc - b_rdcyc, 4);
        if (b_valid && b_pv && !b_pacc) checkOutput("b_hold_data", 32'(b_data), 32'(b_pdata));
        if (b_valid && b_ready) begin
            b_beats++;
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL b_unexpected_beat: got data %0d expected no beat", b_data);
            end else begin
                checkOutput("b_beat_data", 32'(b_data), exp_b.pop_front());
            end
            if (b_last >= 0) checkOutput("b_beat_spacing", cyc - b_last, 6);
            b_last = cyc;
        end
        b_ups  += int'(b_up);
        b_pv    = b_valid;
        b_prd   = b_rd_en;
        b_pacc  = b_valid && b_ready;
        b_pdata = b_data;
    end

    task automatic waitDone(input bit on_b, input int budget);
        int n = 0;
        while (!(on_b ? b_done : a_done) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(on_b ? "b_done_timeout" : "a_done_timeout", 32'(on_b ? b_done : a_done), 1);
    endtask

    task automatic waitIdleA(input int budget);
        int n = 0;
        while (a_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("a_busy_fall", 32'(a_busy), 0);
    endtask

    // Full frame on instance A, with done/busy timing and end-of-frame counts.
    task automatic runFrameA(input string tag, input int gap);
        int ups0, beats0, dones0;
        ups0 = a_ups; beats0 = a_beats; dones0 = a_dones;
        pushFrame(1'b0);
        a_gap  = gap;
        a_last = -1;
        applyStimulus(0);
        waitDone(1'b0, 200);
        checkOutput({tag, "_busy_at_done"}, 32'(a_busy), 0);
        @(negedge clk);
        #2;
        checkOutput({tag, "_done_one_cycle"}, 32'(a_done), 0);
        checkOutput({tag, "_signal_up_count"}, a_ups - ups0, FRAME);
        checkOutput({tag, "_beat_count"}, a_beats - beats0, FRAME);
        checkOutput({tag, "_done_count"}, a_dones - dones0, 1);
        checkOutput({tag, "_cnt_wrapped"}, 32'(a_cnt), 0);
        checkOutput({tag, "_queue_empty"}, exp_a.size(), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, recs0, beats0, dones0;
        a_start = 0; a_abort = 0; a_ready = 1;
        b_start = 0; b_abort = 0; b_ready = 1;
        extra_up = 0;

        #1 rst = 1'b0;
        #1;
        checkOutput("a_reset_outputs", 32'({a_data, a_valid, a_rd_en, a_up, a_rec, a_busy, a_done}), 0);
        checkOutput("b_reset_outputs", 32'({b_data, b_valid, b_rd_en, b_up, b_rec, b_busy, b_done}), 0);
        checkOutput("a_reset_cnt", 32'(a_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] full frame, out_ready high");
        runFrameA("frame1", 4);

        $display("[TB] backpressure on beat 4");
        pushFrame(1'b0);
        a_gap = 0;
        a_last = -1;
        beats0 = a_beats;
        recs0 = a_ups;
        applyStimulus(0);
        n = 0;
        while (!(a_valid && a_data == 16'd12) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_reach_beat4", 32'(a_valid), 1);
        a_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid_held", 32'(a_valid), 1);
            checkOutput("bp_data_stable", 32'(a_data), 12);
            checkOutput("bp_no_signal_up", 32'(a_up), 0);
            @(negedge clk);
        end
        a_ready = 1'b1;
        waitDone(1'b0, 200);
        @(negedge clk);
        #2;
        checkOutput("bp_beat_count", a_beats - beats0, FRAME);
        checkOutput("bp_signal_up_count", a_ups - recs0, FRAME);
        checkOutput("bp_queue_empty", exp_a.size(), 0);

        $display("[TB] RD_LAT=3 frame");
        pushFrame(1'b1);
        b_last = -1;
        beats0 = b_beats;
        recs0 = b_ups;
        applyStimulus(1);
        waitDone(1'b1, 300);
        @(negedge clk);
        #2;
        checkOutput("lat3_beat_count", b_beats - beats0, FRAME);
        checkOutput("lat3_signal_up_count", b_ups - recs0, FRAME);
        checkOutput("lat3_cnt_wrapped", 32'(b_cnt), 0);
        checkOutput("lat3_queue_empty", exp_b.size(), 0);

        $display("[TB] abort in PRESENT at cnt 5");
        for (int i = 0; i < 5; i++) exp_a.push_back(i * 3);
        a_gap = 4;
        a_last = -1;
        applyStimulus(0);
        n = 0;
        while (!(a_valid && a_cnt == 4'd5) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_reach_cnt5", 32'(a_valid), 1);
        recs0 = a_recs;
        dones0 = a_dones;
        a_ready = 1'b0;
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        a_ready = 1'b1;
        checkOutput("abort_valid_drop", 32'(a_valid), 0);
        checkOutput("abort_busy_held", 32'(a_busy), 1);
        waitIdleA(50);
        @(negedge clk);
        #2;
        checkOutput("abort_recover_pulses", a_recs - recs0, 4);
        checkOutput("abort_cnt_zero", 32'(a_cnt), 0);
        checkOutput("abort_no_done", a_dones - dones0, 0);
        checkOutput("abort_queue_empty", exp_a.size(), 0);

        $display("[TB] misaligned start with counter at 7");
        for (int i = 0; i < 7; i++) applyStimulus(3);
        @(negedge clk);
        #2;
        checkOutput("mis_cnt_forced", 32'(a_cnt), 7);
        recs0 = a_recs;
        beats0 = a_beats;
        dones0 = a_dones;
        applyStimulus(0);
        checkOutput("mis_busy", 32'(a_busy), 1);
        waitIdleA(50);
        @(negedge clk);
        #2;
        checkOutput("mis_recover_pulses", a_recs - recs0, 2);
        checkOutput("mis_cnt_zero", 32'(a_cnt), 0);
        checkOutput("mis_no_beats", a_beats - beats0, 0);
        checkOutput("mis_no_done", a_dones - dones0, 0);
        runFrameA("mis_frame", 4);

        $display("[TB] reset during WAIT");
        exp_a.push_back(0);
        exp_a.push_back(3);
        a_gap = 4;
        a_last = -1;
        applyStimulus(0);
        n = 0;
        while (!(a_rd_en && a_addr == 4'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rst_reach_read2", 32'(a_rd_en), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_async_outputs", 32'({a_data, a_valid, a_rd_en, a_up, a_rec, a_busy, a_done}), 0);
        checkOutput("rst_async_cnt", 32'(a_cnt), 0);
        checkOutput("rst_beats_before", exp_a.size(), 0);
        @(negedge clk);
        rst = 1'b1;
        runFrameA("rst_frame", 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_out_streamer.md
Name: ram_out_streamer

Overview:
- Drains the result RAM of the DIM×DIM matrix engine word by word onto a valid/ready output stream (feeds the UART/host serializer).
- Drives the increment inputs of the output-RAM address counter:
  - signal_up connects to that counter's signalUp.
  - signal_up_recover connects to signalup_recover.
- Reads the counter's cnt value back as the RAM read address.
- After an abort, it realigns the counter to 0, because the counter has no synchronous clear.

Parameters:
- DIM, 3, matrix dimension; a frame is DIM*DIM words.
- DATA_W, 16, RAM word / stream width.
- RD_LAT, 1, RAM read latency in cycles from ram_rd_en to valid ram_rdata (legal 1..4).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame. Honoured only in IDLE.
- abort  in  1  one-cycle pulse; cancels the frame. Honoured in any state except IDLE and RECOVER.
- cnt_in  in  CNT_W  address from the counter. CNT_W = $clog2(DIM*DIM-1)+1.
- ram_rd_en  out  1  read strobe to the output RAM.
- ram_addr  out  CNT_W  equals cnt_in (combinational pass-through).
- ram_rdata  in  DATA_W  RAM read data.
- out_data  out  DATA_W  stream data (registered).
- out_valid  out  1  stream valid.
- out_ready  in  1  sink ready.
- signal_up  out  1  one-cycle counter increment pulse.
- signal_up_recover  out  1  recovery increment pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (rst=0, async): state=IDLE, lat counter=0. All outputs 0: out_data, out_valid, ram_rd_en, signal_up, signal_up_recover, busy, done.
- States: IDLE, READ, WAIT, PRESENT, ADVANCE, RECOVER. Encoding is kept in the package.
- IDLE:
  - start=1 with cnt_in==0 → READ.
  - start=1 with cnt_in!=0 → RECOVER; after recovery it returns to IDLE, the start is dropped and done is not pulsed.
- READ: ram_rd_en=1 for exactly this one cycle; load lat counter=RD_LAT-1; → WAIT.
- WAIT:
  - When the lat counter reaches 0, capture ram_rdata into out_data at that edge and → PRESENT.
  - Otherwise decrement the lat counter.
  - With RD_LAT=1, WAIT lasts one cycle.
- PRESENT:
  - out_valid=1 and out_data is held stable until out_ready=1.
  - Accept cycle (out_valid & out_ready): clear out_valid at the next edge; → ADVANCE.
  - The handshake is AXI-style: valid never drops without an accept, and data never changes while valid.
- ADVANCE:
  - signal_up=1 for exactly one cycle.
  - Last word (cnt_in==DIM*DIM-1 in this cycle): the counter wraps to 0 on its own; pulse done in the following cycle; → IDLE.
  - Otherwise → READ. The counter has already updated when READ samples cnt_in.
- Throughput: with RD_LAT=1 and out_ready held at 1, one word every 4 cycles (READ, WAIT, PRESENT, ADVANCE).
- abort:
  - Highest priority. Honoured in READ, WAIT, PRESENT and ADVANCE.
  - Effect at the next edge: out_valid=0, ram_rd_en=0, → RECOVER.
  - abort in the ADVANCE cycle: the signal_up of that cycle is still issued, then → RECOVER.
  - No done pulse.
- RECOVER:
  - signal_up_recover=1 on each cycle where cnt_in!=0.
  - When cnt_in==0 → IDLE, with signal_up_recover=0 in that cycle.
  - Because the counter is registered, there is no overshoot.
  - Length = DIM*DIM - cnt_at_entry cycles of pulses.
  - start and abort are ignored in RECOVER.
- signal_up and signal_up_recover are never high in the same cycle.
- Async reset mid-frame returns to IDLE immediately. The counter is reset by the same rst, so no recovery is needed.
- done and busy are registered: done=1 in the cycle after the final ADVANCE, and busy=0 in that same cycle.

Decomposition:
- Package ram_out_pkg holds:
  - the state enum;
  - the CNT_W function;
  - the FRAME_LEN = DIM*DIM constant.
- The latency counter is inline.
- No sub-module: the address counter stays the existing separate block, instantiated alongside this one in the bench.

Test Plan:
- DIM=3, DATA_W=16, RD_LAT=1; RAM model holds data=addr*3.
  - Stimulus: start with out_ready=1.
  - Required: 9 beats 0,3,…,24; 9 signal_up pulses; cnt_in back to 0; done 1 cycle; beat spacing exactly 4 cycles.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles during beat 4.
  - Required: out_valid held and out_data=12 stable throughout; no extra signal_up; total beats still 9.
- RD_LAT=3:
  - Required: ram_rd_en single-cycle; out_data captured 3 cycles after the strobe; beat spacing 6 cycles.
- Abort in PRESENT at cnt_in=5:
  - Required: out_valid drops next cycle; exactly 4 signal_up_recover pulses; cnt_in=0; busy falls; no done.
- Misaligned start:
  - Stimulus: force the counter to 7 via an extra signal_up, then pulse start.
  - Required: 2 recover pulses, return to IDLE, no beats; a second start then streams a full frame.
- Reset mid-frame:
  - Stimulus: rst low during WAIT.
  - Required: all outputs 0 asynchronously, state IDLE, cnt_in=0; the next start produces a full 9-beat frame.
